// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared integer math helpers for elaboration-time sizing
package math_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/slot_alloc_if.sv
// rtl/slot_alloc_if.sv - alloc (valid/ready) and free ports of the slot allocator
interface slot_alloc_if #(
    parameter int W = 32
) ();
    localparam int IW = $clog2(W);

    logic          alloc_vld_o;
    logic [IW-1:0] alloc_idx_o;
    logic          alloc_rdy_i;
    logic          free_vld_i;
    logic [IW-1:0] free_idx_i;

    modport master (
        input  alloc_vld_o, alloc_idx_o,
        output alloc_rdy_i, free_vld_i, free_idx_i
    );

    modport slave (
        output alloc_vld_o, alloc_idx_o,
        input  alloc_rdy_i, free_vld_i, free_idx_i
    );
endinterface

// File: rtl/e.sv
// rtl/e.sv - circular zero-finder: first zero at pos-1, pos-2, ... with wrap, pos itself last
module e
    import math_pkg::*;
#(
    parameter int W       = 32,
    parameter int RADIX_N = 4,
    localparam int IW     = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    input  logic [IW-1:0] pos_i,
    output logic          any_o,
    output logic [IW-1:0] y_enc_o
);
    localparam int NG = ceil_div(W, RADIX_N);

    logic [NG*RADIX_N-1:0] fr;
    logic [NG-1:0]         grp;
    int                    k_sel;

    // Maps search rank k (0 = pos-1) back to a pool index.
    function automatic logic [IW-1:0] circ_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + W - 1 - k;
        if (s >= W) s = s - W;
        return IW'(s);
    endfunction

    always_comb begin
        fr = '0;
        for (int k = 0; k < W; k++) fr[k] = ~x_i[circ_idx(pos_i, k)];
    end

    always_comb begin
        for (int j = 0; j < NG; j++) grp[j] = |fr[j*RADIX_N +: RADIX_N];
    end

    // Descending scan so the lowest group and lowest rank within it win.
    always_comb begin
        k_sel = 0;
        for (int j = NG - 1; j >= 0; j--) begin
            if (grp[j]) begin
                for (int b = RADIX_N - 1; b >= 0; b--) begin
                    if (fr[j*RADIX_N + b]) k_sel = j*RADIX_N + b;
                end
            end
        end
    end

    assign any_o   = |grp;
    assign y_enc_o = circ_idx(pos_i, k_sel);
endmodule

// File: rtl/slot_alloc.sv
// rtl/slot_alloc.sv - round-robin free-slot allocator with one pre-reserved index
module slot_alloc #(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    slot_alloc_if.slave            sif,
    output logic [$clog2(W+1)-1:0] cnt_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          any;
    logic [IW-1:0] y_enc;
    logic          acc, ld, reserved_hit, legal_free, illegal_free;

    e #(.W(W), .RADIX_N(RADIX_N)) u_e (
        .x_i     (busy_q),
        .pos_i   (ptr_q),
        .any_o   (any),
        .y_enc_o (y_enc)
    );

    always_comb begin
        acc          = vld_q & sif.alloc_rdy_i;
        ld           = any & (~vld_q | acc);
        reserved_hit = vld_q & (sif.free_idx_i == idx_q);
    end

    // Returning an idle slot or the still-unaccepted reserved slot.
    always_comb begin
        illegal_free = sif.free_vld_i & ~(busy_q[sif.free_idx_i] & ~reserved_hit);
    end

    assign legal_free = sif.free_vld_i & ~illegal_free;

    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        vld_d  = vld_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        err_d  = err_q | illegal_free;
        // ld and legal_free never collide: e only picks slots that are idle.
        if (legal_free) busy_d[sif.free_idx_i] = 1'b0;
        if (ld) begin
            busy_d[y_enc] = 1'b1;
            idx_d         = y_enc;
            ptr_d         = y_enc;
            vld_d         = 1'b1;
        end else if (acc) begin
            vld_d = 1'b0;
        end
        case ({ld, legal_free})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q <= '0;
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign sif.alloc_vld_o = vld_q;
    assign sif.alloc_idx_o = idx_q;
    assign cnt_o           = cnt_q;
    assign err_o           = err_q;
    assign full_o          = (cnt_q == CW'(W));
    assign empty_o         = (cnt_q == '0);
endmodule

// File: tb/tb_slot_alloc.sv
// tb/tb_slot_alloc.sv - self-checking bench for slot_alloc with an index scoreboard
module tb_slot_alloc;
    localparam int W  = 16;
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [CW-1:0] cnt;
    logic          full, empty, err;

    slot_alloc_if #(.W(W)) sif ();

    slot_alloc #(.W(W), .RADIX_N(4)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .sif     (sif),
        .cnt_o   (cnt),
        .full_o  (full),
        .empty_o (empty),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [IW-1:0] exp_q[$];

    task automatic apply_reset(input logic rdy);
        @(negedge clk);
        arst_n = 1'b0;
        sif.alloc_rdy_i = rdy;
        sif.free_vld_i = 1'b0;
        sif.free_idx_i = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Checks the current cycle, then advances; stops after n accepts or budget cycles.
    task automatic run_accepts(input string name, input int n, input int budget);
        int got = 0;
        logic [IW-1:0] ex;
        for (int c = 0; c < budget && got < n; c++) begin
            if (sif.alloc_vld_o && sif.alloc_rdy_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra got=%0d exp=none", name, sif.alloc_idx_o);
                end else begin
                    ex = exp_q.pop_front();
                    if (sif.alloc_idx_o !== ex) begin
                        failures++;
                        $display("FAIL %s_idx got=%0d exp=%0d", name, sif.alloc_idx_o, ex);
                    end
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got, n);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 10 && !sif.alloc_vld_o; c++) @(negedge clk);
        checks++;
        if (sif.alloc_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait_vld got=%0b exp=1", name, sif.alloc_vld_o);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (sif.alloc_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld got=%0b exp=0", sif.alloc_vld_o); end
        checks++; if (sif.alloc_idx_o !== '0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", sif.alloc_idx_o); end
        checks++; if (cnt !== '0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=10", empty, full); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
    endtask

    task automatic test_fill();
        apply_reset(1'b1);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(IW'(i));
        run_accepts("fill", W, 40);
        checks++; if (sif.alloc_vld_o !== 1'b0) begin failures++; $display("FAIL fill_vld got=%0b exp=0", sif.alloc_vld_o); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
        checks++; if (cnt !== CW'(W)) begin failures++; $display("FAIL fill_cnt got=%0d exp=%0d", cnt, W); end
    endtask

    task automatic test_free_full();
        sif.free_vld_i = 1'b1;
        sif.free_idx_i = IW'(9);
        exp_q.push_back(IW'(9));
        @(negedge clk);
        sif.free_vld_i = 1'b0;
        checks++; if (cnt !== CW'(W - 1)) begin failures++; $display("FAIL ff_cnt got=%0d exp=%0d", cnt, W - 1); end
        checks++; if (sif.alloc_vld_o !== 1'b0) begin failures++; $display("FAIL ff_no_bypass got=%0b exp=0", sif.alloc_vld_o); end
        @(negedge clk);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ff_full got=%0b exp=1", full); end
        run_accepts("ff", 1, 3);
        checks++; if (sif.alloc_vld_o !== 1'b0) begin failures++; $display("FAIL ff_vld_end got=%0b exp=0", sif.alloc_vld_o); end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        exp_q.push_back(IW'(15));
        exp_q.push_back(IW'(14));
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            checks++; if (sif.alloc_idx_o !== exp_q[0]) begin failures++; $display("FAIL bp_hold_idx got=%0d exp=%0d", sif.alloc_idx_o, exp_q[0]); end
            checks++; if (cnt !== CW'(1)) begin failures++; $display("FAIL bp_hold_cnt got=%0d exp=1", cnt); end
            @(negedge clk);
        end
        sif.alloc_rdy_i = 1'b1;
        run_accepts("bp", 2, 6);
        sif.alloc_rdy_i = 1'b0;
    endtask

    task automatic test_simul_free();
        apply_reset(1'b1);
        for (int i = W - 1; i >= 3; i--) exp_q.push_back(IW'(i));
        run_accepts("sim_pre", 13, 30);
        exp_q.push_back(IW'(2));
        exp_q.push_back(IW'(1));
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(3));
        checks++; if (cnt !== CW'(14)) begin failures++; $display("FAIL sim_cnt_before got=%0d exp=14", cnt); end
        sif.free_vld_i = 1'b1;
        sif.free_idx_i = IW'(3);
        run_accepts("sim_acc", 1, 2);
        sif.free_vld_i = 1'b0;
        checks++; if (cnt !== CW'(14)) begin failures++; $display("FAIL sim_cnt_after got=%0d exp=14", cnt); end
        run_accepts("sim_wrap", 3, 10);
        checks++; if (cnt !== CW'(W) || full !== 1'b1) begin failures++; $display("FAIL sim_final got=%0d/%0b exp=%0d/1", cnt, full, W); end
    endtask

    task automatic test_illegal_free();
        apply_reset(1'b0);
        wait_valid("err_res");
        sif.free_vld_i = 1'b1;
        sif.free_idx_i = IW'(15);
        @(negedge clk);
        sif.free_vld_i = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_reserved got=%0b exp=1", err); end
        checks++; if (cnt !== CW'(1)) begin failures++; $display("FAIL err_reserved_cnt got=%0d exp=1", cnt); end
        checks++; if (sif.alloc_vld_o !== 1'b1 || sif.alloc_idx_o !== IW'(15)) begin failures++; $display("FAIL err_reserved_hold got=%0b/%0d exp=1/15", sif.alloc_vld_o, sif.alloc_idx_o); end
        apply_reset(1'b0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", err); end
        wait_valid("err_idle");
        sif.free_vld_i = 1'b1;
        sif.free_idx_i = IW'(5);
        @(negedge clk);
        sif.free_vld_i = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_idle got=%0b exp=1", err); end
        checks++; if (cnt !== CW'(1)) begin failures++; $display("FAIL err_idle_cnt got=%0d exp=1", cnt); end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
        exp_q.push_back(IW'(15));
        exp_q.push_back(IW'(14));
        sif.alloc_rdy_i = 1'b1;
        run_accepts("err_after", 2, 6);
        sif.alloc_rdy_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        for (int i = W - 1; i >= W - 7; i--) exp_q.push_back(IW'(i));
        run_accepts("mid_pre", 7, 20);
        #2 arst_n = 1'b0;
        #1;
        checks++; if (sif.alloc_vld_o !== 1'b0 || sif.alloc_idx_o !== '0) begin failures++; $display("FAIL mid_port got=%0b/%0d exp=0/0", sif.alloc_vld_o, sif.alloc_idx_o); end
        checks++; if (cnt !== '0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_cnt got=%0d/%0b exp=0/1", cnt, empty); end
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        exp_q.push_back(IW'(15));
        run_accepts("mid_post", 1, 4);
    endtask

    initial begin
        sif.alloc_rdy_i = 1'b0;
        sif.free_vld_i  = 1'b0;
        sif.free_idx_i  = '0;
        test_reset();
        test_fill();
        test_free_full();
        test_backpressure();
        test_simul_free();
        test_illegal_free();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
